rom_fetch_responder: RTL and testbench
======================================

Name: rom_fetch_responder

Overview:
- Responder end of the IF-stage ROM fetch interface.
- Accepts the PC's combinational fetch address on `rom_en`/`rom_addr` and returns the instruction word one clock later, in step with the PC register.
- Backed by a slower handshaked external instruction memory, fronted by a single-entry word buffer.
- On a buffer miss it raises a combinational stall request that holds the PC until the word arrives.

Parameters:
- TIMEOUT, 16: max BUSY cycles waiting for `mem_ack` before abandoning the fetch (≥2).
- NOP_WORD, 32'h00000000: instruction substituted on timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- rom_en  in  1  fetch enable from PC
- rom_write_en  in  `MEM_SEL_BUS` (4)  byte write strobes (read-only target)
- rom_addr  in  `ADDR_BUS` (32)  fetch address, combinational, valid in the same cycle
- rom_write_data  in  `DATA_BUS` (32)  unused write data
- rom_read_data  out  `DATA_BUS`  instruction for address accepted last cycle
- stall_req  out  1  combinational; high means PC must hold
- bus_err  out  1  one-cycle pulse on fetch timeout
- mem_req  out  1  external read request, registered
- mem_addr  out  `ADDR_BUS`  external word address, registered
- mem_ack  in  1  external read complete, single-cycle pulse
- mem_rdata  in  `DATA_BUS`  read data, valid with `mem_ack`

Behaviour:
- Buffer: `buf_valid`, `buf_tag[29:0]`, `buf_data[31:0]`.
  - `hit = buf_valid && buf_tag == rom_addr[31:2]`.
  - `rom_addr[1:0]` is ignored for the hit compare and for `mem_addr`; `mem_addr = {req_tag, 2'b00}`.
- `stall_req = rom_en && (!hit || state != IDLE)`.
- On any edge where `rom_en && !stall_req`: `rom_read_data <= buf_data`. Hit latency is 0 stall cycles and data lands on the next cycle.
- `rom_en` low: no request issued, `stall_req` = 0, `rom_read_data` holds its value.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - If `rom_en && !hit`: `req_tag <= rom_addr[31:2]`, `mem_req <= 1`, `wait_cnt <= 0`, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - `mem_req` stays 1 and `wait_cnt` increments each cycle.
  - On `mem_ack`:
    - Set `buf_tag <= req_tag`, `buf_data <= mem_rdata`, `buf_valid <= 1`.
    - Set `mem_req <= 0` and go to IDLE.
  - On timeout (`wait_cnt == TIMEOUT-1` and no ack):
    - Fill the buffer with `req_tag`/NOP_WORD.
    - Set `mem_req <= 0`, pulse `bus_err` for 1 cycle, go to IDLE.
  - `mem_ack` on the timeout cycle counts as an ack; `bus_err` stays 0.
- Miss cost: request issued the cycle after detection; `stall_req` drops the cycle after the ack.
- Address change while BUSY (flush/branch moved `next_pc`):
  - The outstanding transaction always completes and fills the buffer with the old tag.
  - The next IDLE cycle misses on the new address and issues a fresh request.
  - A request is never aborted mid-flight.
- `rom_write_en != 0` with `rom_en`:
  - Clears `buf_valid` on that edge; no write reaches external memory.
  - In BUSY, the completing fill still sets valid.
- `mem_ack` in IDLE is ignored.
- Reset:
  - State IDLE, `buf_valid` 0, `buf_tag` 0, `buf_data` 0, `rom_read_data` 0.
  - `mem_req` 0, `mem_addr` 0, `bus_err` 0, `wait_cnt` 0.
  - Reset mid-BUSY drops the request immediately; a later stray ack is ignored.

Optional Feature:
- Macro `ROM_FETCH_ALIGN_CHECK_EN`.
- When defined, IDLE checks `rom_addr[1:0] != 0` before the hit check:
  - No memory request is issued.
  - `rom_read_data <= NOP_WORD` and `bus_err` pulses for 1 cycle.
  - `stall_req` = 0 and the buffer is unchanged.
- When undefined, the low address bits are silently ignored.

Decomposition:
- Bus widths (`ADDR_BUS`, `DATA_BUS`, `MEM_SEL_BUS`) and `INIT_PC` come from the shared bus/pc headers.
- Add `FETCH_NOP` to the shared header as the default for NOP_WORD.
- FSM state encoding stays local.
- No sub-module is natural: the buffer, FSM and timeout counter are small and tightly coupled, so keep them inline.

Test Plan:
- Reset, then `rom_en=1`, `rom_addr=0xBFC00000`, memory acks after 3 cycles with `0x24080001` → `stall_req` high 5 cycles, `mem_addr=0xBFC00000`, `rom_read_data=0x24080001` the cycle after stall drops.
- Same address held 4 more cycles → `stall_req` 0 every cycle, `mem_req` stays 0, `rom_read_data` stable.
- Address changes to `0xBFC00004` on the cycle after the request issues → first fill completes for `0xBFC00000`, then a second request to `0xBFC00004`; final data matches the second ack.
- No `mem_ack` for TIMEOUT=16 cycles → `bus_err` high exactly 1 cycle, `rom_read_data=0x00000000`, `stall_req` releases.
- `rst` asserted on the 2nd BUSY cycle, ack arrives 2 cycles later → `mem_req` 0 after reset, ack ignored, next fetch re-requests.
- With `ROM_FETCH_ALIGN_CHECK_EN` defined, `rom_addr=0xBFC00002` → `bus_err` pulse, NOP returned, no `mem_req`.

Source files
------------

// File: rtl/rom_fetch_responder_pkg.sv
// Shared fetch-bus widths, types and the default NOP instruction.
// Imported by the fetch responder, its memory-bus interface and the bench.
package rom_fetch_responder_pkg;

  localparam int ADDR_BUS    = 32;
  localparam int DATA_BUS    = 32;
  localparam int MEM_SEL_BUS = 4;

  typedef logic [ADDR_BUS-1:0]    addr_t;
  typedef logic [DATA_BUS-1:0]    data_t;
  typedef logic [MEM_SEL_BUS-1:0] sel_t;
  typedef logic [ADDR_BUS-3:0]    tag_t;

  localparam data_t FETCH_NOP = 32'h0000_0000;

endpackage

// File: rtl/rom_fetch_responder_if.sv
// External instruction-memory read handshake.
// master: mem_req/mem_addr out, mem_ack/mem_rdata in; slave is the mirror.
interface rom_fetch_responder_if;
  import rom_fetch_responder_pkg::*;

  logic  mem_req;
  addr_t mem_addr;
  logic  mem_ack;
  data_t mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/rom_fetch_responder.sv
// IF-stage ROM responder: one-word buffer over a handshaked memory.
// Ports: clk, rst (sync, high); rom_en/rom_write_en/rom_addr/
// rom_write_data in; rom_read_data, stall_req, bus_err out;
// mem (master) to external memory. Option: ROM_FETCH_ALIGN_CHECK_EN.
module rom_fetch_responder
  import rom_fetch_responder_pkg::*;
#(
  parameter int    TIMEOUT  = 16,
  parameter data_t NOP_WORD = FETCH_NOP
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rom_en,
  input  sel_t  rom_write_en,
  input  addr_t rom_addr,
  input  data_t rom_write_data,
  output data_t rom_read_data,
  output logic  stall_req,
  output logic  bus_err,
  rom_fetch_responder_if.master mem
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state;
  logic          buf_valid;
  tag_t          buf_tag;
  data_t         buf_data;
  tag_t          req_tag;
  logic          mem_req_q;
  logic [CW-1:0] wait_cnt;

  logic hit;
  logic misalign;
  logic unused_ok;

  assign hit = buf_valid && (buf_tag == rom_addr[31:2]);

`ifdef ROM_FETCH_ALIGN_CHECK_EN
  assign misalign = |rom_addr[1:0];
`else
  assign misalign = 1'b0;
`endif

  // Misaligned fetches are answered in IDLE without memory traffic.
  assign stall_req = rom_en &&
    ((state != IDLE) || (!misalign && !hit));

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = {req_tag, 2'b00};

  assign unused_ok = ^{rom_write_data, rom_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      buf_valid     <= 1'b0;
      buf_tag       <= '0;
      buf_data      <= '0;
      req_tag       <= '0;
      mem_req_q     <= 1'b0;
      wait_cnt      <= '0;
      bus_err       <= 1'b0;
      rom_read_data <= '0;
    end else begin
      bus_err <= 1'b0;

      if (rom_en && !stall_req)
        rom_read_data <= misalign ? NOP_WORD : buf_data;

      // Writes to a ROM only invalidate; a fill below overrides.
      if (rom_en && (rom_write_en != '0))
        buf_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (rom_en && misalign) begin
            bus_err <= 1'b1;
          end else if (rom_en && !hit) begin
            req_tag   <= rom_addr[31:2];
            mem_req_q <= 1'b1;
            wait_cnt  <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem.mem_ack) begin
            buf_tag   <= req_tag;
            buf_data  <= mem.mem_rdata;
            buf_valid <= 1'b1;
            mem_req_q <= 1'b0;
            state     <= IDLE;
          end else if (wait_cnt == LAST) begin
            buf_tag   <= req_tag;
            buf_data  <= NOP_WORD;
            buf_valid <= 1'b1;
            mem_req_q <= 1'b0;
            bus_err   <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_responder.sv
// Directed bench for rom_fetch_responder.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_rom_fetch_responder;
  import rom_fetch_responder_pkg::*;

  logic  clk;
  logic  rst;
  logic  rom_en;
  sel_t  rom_write_en;
  addr_t rom_addr;
  data_t rom_write_data;
  data_t rom_read_data;
  logic  stall_req;
  logic  bus_err;

  int n_tests;
  int n_fail;

  rom_fetch_responder_if mif ();

  rom_fetch_responder dut (
    .clk            (clk),
    .rst            (rst),
    .rom_en         (rom_en),
    .rom_write_en   (rom_write_en),
    .rom_addr       (rom_addr),
    .rom_write_data (rom_write_data),
    .rom_read_data  (rom_read_data),
    .stall_req      (stall_req),
    .bus_err        (bus_err),
    .mem            (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (rom_read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata got %h exp 0", rom_read_data);
    end
    n_tests++;
    if (mif.mem_req !== 1'b0 || mif.mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem got %b/%h exp 0/0",
               mif.mem_req, mif.mem_addr);
    end
    n_tests++;
    if (bus_err !== 1'b0 || stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b/%b exp 0/0",
               bus_err, stall_req);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_miss();
    int stalls;
    stalls = 0;
    rom_en   = 1'b1;
    rom_addr = 32'hBFC0_0000;
    for (int c = 0; c < 8; c++) begin
      mif.mem_ack   = (c == 4);
      mif.mem_rdata = 32'h2408_0001;
      @(negedge clk);
      if (stall_req) stalls++;
      if (c == 2) begin
        n_tests++;
        if (mif.mem_req !== 1'b1 ||
            mif.mem_addr !== 32'hBFC0_0000) begin
          n_fail++;
          $display("FAIL miss_req got %b/%h exp 1/bfc00000",
                   mif.mem_req, mif.mem_addr);
        end
      end
      if (c == 6) begin
        n_tests++;
        if (rom_read_data !== 32'h2408_0001) begin
          n_fail++;
          $display("FAIL miss_rdata got %h exp 24080001",
                   rom_read_data);
        end
      end
      next_cycle();
    end
    mif.mem_ack = 1'b0;
    n_tests++;
    if (stalls != 5) begin
      n_fail++;
      $display("FAIL miss_stall_cycles got %0d exp 5", stalls);
    end
  endtask

  task automatic test_hit();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (stall_req !== 1'b0 || mif.mem_req !== 1'b0 ||
          rom_read_data !== 32'h2408_0001) begin
        n_fail++;
        $display("FAIL hit_%0d got %b/%b/%h exp 0/0/24080001",
                 c, stall_req, mif.mem_req, rom_read_data);
      end
      next_cycle();
    end
  endtask

  task automatic test_en_low();
    rom_en   = 1'b0;
    rom_addr = 32'hBFC0_0800;
    @(negedge clk);
    n_tests++;
    if (stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL en_low_stall got %b exp 0", stall_req);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (mif.mem_req !== 1'b0 ||
        rom_read_data !== 32'h2408_0001) begin
      n_fail++;
      $display("FAIL en_low_hold got %b/%h exp 0/24080001",
               mif.mem_req, rom_read_data);
    end
    next_cycle();
  endtask

  task automatic test_addr_change();
    rom_en       = 1'b1;
    rom_addr     = 32'hBFC0_0000;
    rom_write_en = 4'hF;
    @(negedge clk);
    n_tests++;
    if (stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_hit_stall got %b exp 0", stall_req);
    end
    next_cycle();
    rom_write_en = 4'h0;
    @(negedge clk);
    n_tests++;
    if (stall_req !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_invalidate got %b exp 1", stall_req);
    end
    next_cycle();
    rom_addr = 32'hBFC0_0004;
    @(negedge clk);
    n_tests++;
    if (mif.mem_addr !== 32'hBFC0_0000) begin
      n_fail++;
      $display("FAIL chg_first_addr got %h exp bfc00000",
               mif.mem_addr);
    end
    next_cycle();
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h1111_1111;
    next_cycle();
    mif.mem_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if (stall_req !== 1'b1 || mif.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL chg_remiss got %b/%b exp 1/0",
               stall_req, mif.mem_req);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (mif.mem_req !== 1'b1 ||
        mif.mem_addr !== 32'hBFC0_0004) begin
      n_fail++;
      $display("FAIL chg_second_req got %b/%h exp 1/bfc00004",
               mif.mem_req, mif.mem_addr);
    end
    next_cycle();
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h2222_2222;
    next_cycle();
    mif.mem_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if (stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL chg_release got %b exp 0", stall_req);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (rom_read_data !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL chg_rdata got %h exp 22222222",
               rom_read_data);
    end
    next_cycle();
  endtask

  task automatic run_long(input addr_t a, input int ack_c,
                          input data_t d, input string nm);
    int stalls;
    int errs;
    stalls = 0;
    errs   = 0;
    rom_en   = 1'b1;
    rom_addr = a;
    for (int c = 0; c < 20; c++) begin
      mif.mem_ack   = (c == ack_c);
      mif.mem_rdata = 32'h3333_3333;
      @(negedge clk);
      if (stall_req) stalls++;
      if (bus_err) errs++;
      if (c == 18) begin
        n_tests++;
        if (rom_read_data !== d) begin
          n_fail++;
          $display("FAIL %s_rdata got %h exp %h",
                   nm, rom_read_data, d);
        end
      end
      if (c == 17) begin
        n_tests++;
        if (mif.mem_req !== 1'b0 || stall_req !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_release got %b/%b exp 0/0",
                   nm, mif.mem_req, stall_req);
        end
      end
      next_cycle();
    end
    mif.mem_ack = 1'b0;
    n_tests++;
    if (stalls != 17) begin
      n_fail++;
      $display("FAIL %s_stalls got %0d exp 17", nm, stalls);
    end
    n_tests++;
    if (errs != ((ack_c < 0) ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s_bus_err got %0d exp %0d",
               nm, errs, (ack_c < 0) ? 1 : 0);
    end
  endtask

  task automatic test_timeout();
    run_long(32'hBFC0_0100, -1, 32'h0, "timeout");
  endtask

  task automatic test_ack_at_timeout();
    run_long(32'hBFC0_0200, 16, 32'h3333_3333, "late_ack");
  endtask

  task automatic test_reset_busy();
    rom_en   = 1'b1;
    rom_addr = 32'hBFC0_0300;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst    = 1'b0;
    rom_en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mif.mem_req !== 1'b0 || rom_read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rstbusy_drop got %b/%h exp 0/0",
               mif.mem_req, rom_read_data);
    end
    next_cycle();
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h4444_4444;
    next_cycle();
    mif.mem_ack = 1'b0;
    rom_en      = 1'b1;
    @(negedge clk);
    n_tests++;
    if (stall_req !== 1'b1 || mif.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rstbusy_stray got %b/%b exp 1/0",
               stall_req, mif.mem_req);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (mif.mem_req !== 1'b1 ||
        mif.mem_addr !== 32'hBFC0_0300) begin
      n_fail++;
      $display("FAIL rstbusy_rereq got %b/%h exp 1/bfc00300",
               mif.mem_req, mif.mem_addr);
    end
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h5555_5555;
    next_cycle();
    mif.mem_ack = 1'b0;
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (rom_read_data !== 32'h5555_5555) begin
      n_fail++;
      $display("FAIL rstbusy_rdata got %h exp 55555555",
               rom_read_data);
    end
    next_cycle();
  endtask

`ifdef ROM_FETCH_ALIGN_CHECK_EN
  task automatic test_align();
    rom_addr = 32'hBFC0_0002;
    @(negedge clk);
    n_tests++;
    if (stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL align_stall got %b exp 0", stall_req);
    end
    next_cycle();
    rom_addr = 32'hBFC0_0300;
    @(negedge clk);
    n_tests++;
    if (bus_err !== 1'b1 || rom_read_data !== 32'h0 ||
        mif.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL align_resp got %b/%h/%b exp 1/0/0",
               bus_err, rom_read_data, mif.mem_req);
    end
    n_tests++;
    if (stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL align_buf_kept got %b exp 0", stall_req);
    end
    next_cycle();
  endtask
`else
  task automatic test_low_bits();
    rom_addr = 32'hBFC0_0302;
    @(negedge clk);
    n_tests++;
    if (stall_req !== 1'b0 || mif.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL low_bits got %b/%b exp 0/0",
               stall_req, mif.mem_req);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (rom_read_data !== 32'h5555_5555 || bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL low_bits_data got %h/%b exp 55555555/0",
               rom_read_data, bus_err);
    end
    next_cycle();
  endtask
`endif

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    rom_en         = 1'b0;
    rom_write_en   = 4'h0;
    rom_addr       = 32'h0;
    rom_write_data = 32'hDEAD_BEEF;
    mif.mem_ack    = 1'b0;
    mif.mem_rdata  = 32'h0;
    test_reset();
    test_miss();
    test_hit();
    test_en_low();
    test_addr_change();
    test_timeout();
    test_ack_at_timeout();
    test_reset_busy();
`ifdef ROM_FETCH_ALIGN_CHECK_EN
    test_align();
`else
    test_low_bits();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
